// File: rtl/seq_mul_add.sv
// seq_mul_add
//   Sequential shift-and-add multiply-accumulate unit computing a*b + c.
//   Feeding a divider's quotient, divisor and remainder rebuilds the
//   dividend, so the block doubles as a divider checker and a small
//   multiplier.
//
//   Ports
//     clk_i        rising-edge clock
//     rst_ni       asynchronous reset, active low
//     in_valid_i   operands a/b/c are valid
//     in_ready_o   block can accept operands (IDLE only)
//     a_i          multiplicand, unsigned, WIDTH bits
//     b_i          multiplier, unsigned, WIDTH bits
//     c_i          addend, unsigned, WIDTH bits
//     out_valid_o  product is valid (DONE only)
//     out_ready_i  consumer accepts the product
//     product_o    a*b + c, unsigned, 2*WIDTH bits
//     busy_o       high while an operation is in RUN or DONE
module seq_mul_add #(
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH-1:0]   c_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);

  // The counter must be able to hold WIDTH-1; one extra bit keeps it safe
  // for any WIDTH.
  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q;
  logic               inReady_q;
  logic               outValid_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0]   bSh_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNTW-1:0]    cnt_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [CNTW-1:0]    cnt_d;

  // Partial-product step: add the shifted multiplicand when the current
  // multiplier bit is set. The accumulator is 2*WIDTH bits wide and the
  // largest a*b+c is 2^(2W)-2^W, so the sum never carries out.
  always_comb begin
    acc_d = acc_q;
    if (bSh_q[0]) begin
      acc_d = acc_q + aSh_q;
    end
    cnt_d = cnt_q + CNTW'(1);
  end

  // Control FSM and datapath registers. All handshake outputs are
  // registered so they change only on clock edges (or reset). The latency
  // is fixed at WIDTH RUN cycles even if the multiplier runs out of ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      product_q  <= '0;
      aSh_q      <= '0;
      bSh_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i && inReady_q) begin
            aSh_q     <= {{WIDTH{1'b0}}, a_i};
            bSh_q     <= b_i;
            acc_q     <= {{WIDTH{1'b0}}, c_i};
            cnt_q     <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          aSh_q <= aSh_q << 1;
          bSh_q <= bSh_q >> 1;
          cnt_q <= cnt_d;
          if (cnt_q == CNTW'(WIDTH - 1)) begin
            product_q  <= acc_d;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // in_ready stays low through the handshake cycle, so a new
          // operand set is taken no earlier than the following edge.
          if (outValid_q && out_ready_i) begin
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign busy_o      = busy_q;
  assign product_o   = product_q;

endmodule
